seven_seg_scan_ctrl: RTL and testbench
======================================

// Module: seven_seg_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for a common-select multi-digit 7-segment display.
//  Takes the display value from the host through a load/ack shadow register and cycles the digit selects with an anti-ghosting blank gap.
//  Drives a single shared hex-to-7-segment decoder, adds per-digit decimal point and optional leading-zero blanking.
//  Sits between the board-level display pins and any counter/status logic producing a hex value.
// PARAMETERS
//  NUM_DIGITS      4     number of digits scanned; digit 0 = rightmost = i_value[3:0]
//  TICKS_PER_DIGIT 1000  clocks per digit slot (blank + show); >= BLANK_TICKS+1
//  BLANK_TICKS     16    clocks at start of each slot with all selects/segments inactive; >= 1
//  DIG_ACTIVE_LOW  1     1: o_digitSel active-low; 0: active-high
//  SEG_ACTIVE_LOW  0     1: o_segVals inverted at output; 0: bit=1 lights segment
// PORTS
//  i_clk          in   1             system clock
//  i_reset        in   1             synchronous, active-high reset
//  i_value        in   4*NUM_DIGITS  hex nibbles to display, sampled on i_load
//  i_dp           in   NUM_DIGITS    decimal point per digit, sampled on i_load
//  i_lzSuppress   in   1             1: blank leading zero digits (live, not shadowed)
//  i_load         in   1             1-cycle request: capture i_value/i_dp into pending reg
//  o_loadAck      out  1             1-cycle pulse when pending reg moved to display reg
//  o_frame        out  1             1-cycle pulse at start of every frame
//  o_segVals      out  8             segments {dp,g,f,e,d,c,b,a}, registered
//  o_digitSel     out  NUM_DIGITS    one-hot (per polarity) digit select, registered
// BEHAVIOUR
//  Reset (sync, i_reset=1 at clock edge, any state): state=BLANK, digit=0, tick=0, pending/display regs=0,
//   pendFlag=0; o_segVals=inactive (0 ^ SEG_ACTIVE_LOW mask), o_digitSel=all inactive, o_loadAck=0, o_frame=0.
//   Reset mid-scan aborts immediately; a pending, unacked load is discarded.
//  FSM: BLANK (BLANK_TICKS clocks) -> SHOW (TICKS_PER_DIGIT-BLANK_TICKS clocks) -> BLANK of next digit.
//   tick counter restarts at 0 on each state entry. digit increments at SHOW->BLANK; wraps NUM_DIGITS-1 -> 0.
//  Frame = NUM_DIGITS*TICKS_PER_DIGIT clocks exactly. Frame boundary = first cycle of digit-0 BLANK
//   (not the first cycle after reset); o_frame=1 on exactly that cycle.
//  Outputs registered: o_digitSel/o_segVals reflect the state of the same cycle; select and segments change on the same edge.
//  BLANK: all selects inactive, segments inactive. SHOW: select[digit] active, others inactive;
//   segs[6:0] = hex decode of display nibble[digit], segs[7] = display dp[digit].
//  Leading-zero suppression (i_lzSuppress=1): digit k>0 blanked (segs[6:0]=0) when nibbles k..NUM_DIGITS-1
//   are all zero; digit 0 never blanked; dp still shown on blanked digits; select still driven.
//  Load handshake: i_load=1 writes pending <= {i_value,i_dp}, pendFlag <= 1; repeated loads overwrite (latest wins).
//   At frame boundary with pendFlag=1: display <= pending, o_loadAck=1 that cycle, pendFlag cleared.
//   i_load on the boundary cycle itself: transfer uses the pre-edge pending contents and is acked now;
//   new data lands in pending, pendFlag stays 1, acked at next boundary.
//  Display reg only changes at frame boundaries -> no torn values within a frame.
// STRUCTURE
//  Shared header seven_seg_defs.vh: FSM state encodings (BLANK, SHOW), SEG_BLANK constant, segment bit indices.
//  One sub-module: hex_to_7seg (existing team decoder), single instance fed by mux of display[digit].
//  Counters sized with $clog2(TICKS_PER_DIGIT) and $clog2(NUM_DIGITS) (min 1 bit).
// TESTING  (NUM_DIGITS=4, TICKS_PER_DIGIT=8, BLANK_TICKS=2, DIG_ACTIVE_LOW=1, SEG_ACTIVE_LOW=0)
//  Reset 3 cycles during a digit-2 SHOW -> next cycle o_digitSel=4'b1111, o_segVals=8'h00, ack=0, frame=0.
//  Scan timing: each select low 6 clocks, then 2 clocks all-high; order 1110,1101,1011,0111; o_frame period 32.
//  i_load with i_value=16'h1234, i_dp=0 -> one o_loadAck at next boundary; digit0 segs=8'h66, digit3 segs=8'h06.
//  i_value=16'h0050, lz=1 -> digits 3,2 segs 8'h00, digit1 8'h6d, digit0 8'h3f; value 16'h0000 -> digit0 8'h3f only.
//  Load A=16'hAAAA then B=16'hBBBB before boundary -> single ack, all digits 8'h7c; load C on boundary cycle -> ack now for B, C acked next frame.
//  i_value=16'h0008, i_dp=4'b0001, lz=1 -> digit0 segs=8'hff; digits 3..1 segs=8'h00.

Source files
------------

// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller.
//   - scan FSM state encoding
//   - segment bit positions within the 8-bit {dp,g,f,e,d,c,b,a} bus
//   - the all-off segment pattern (before output polarity is applied)
//   - a width helper that never returns zero bits
package seven_seg_scan_ctrl_pkg;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Counter width for a range of n values; a 1-value range still needs one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_hex_to_7seg.sv
// Hex nibble to 7-segment pattern decoder (team decoder, purely combinational).
// Ports:
//   i_nibble  in  4  hex digit 0..F
//   o_seg     out 7  segments {g,f,e,d,c,b,a}, 1 = lit
// Letters b and d use lower-case shapes so they differ from 8 and 0.
module hex_to_7seg (
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h00;
    case (i_nibble)
      4'h0: o_seg = 7'h3f;
      4'h1: o_seg = 7'h06;
      4'h2: o_seg = 7'h5b;
      4'h3: o_seg = 7'h4f;
      4'h4: o_seg = 7'h66;
      4'h5: o_seg = 7'h6d;
      4'h6: o_seg = 7'h7d;
      4'h7: o_seg = 7'h07;
      4'h8: o_seg = 7'h7f;
      4'h9: o_seg = 7'h6f;
      4'hA: o_seg = 7'h77;
      4'hB: o_seg = 7'h7c;
      4'hC: o_seg = 7'h39;
      4'hD: o_seg = 7'h5e;
      4'hE: o_seg = 7'h79;
      4'hF: o_seg = 7'h71;
      default: o_seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Each digit slot is BLANK_TICKS clocks of everything off (anti-ghosting)
// followed by TICKS_PER_DIGIT-BLANK_TICKS clocks showing that digit.
// Host data enters through a pending register and is copied to the display
// register only at frame boundaries, so a frame never shows a torn value.
// Ports:
//   i_clk         in   1             system clock
//   i_reset       in   1             synchronous active-high reset
//   i_value       in   4*NUM_DIGITS  hex nibbles, digit 0 = [3:0], captured on i_load
//   i_dp          in   NUM_DIGITS    decimal point per digit, captured on i_load
//   i_lzSuppress  in   1             blank leading zero digits (live input)
//   i_load        in   1             capture i_value/i_dp into the pending register
//   o_loadAck     out  1             pulse when pending data moves to the display
//   o_frame       out  1             pulse on the first cycle of each frame
//   o_segVals     out  8             {dp,g,f,e,d,c,b,a}, registered
//   o_digitSel    out  NUM_DIGITS    digit select, registered
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int TICKS_PER_DIGIT = 1000,
  parameter int BLANK_TICKS     = 16,
  parameter bit DIG_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_LOW  = 1'b0
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [4*NUM_DIGITS-1:0]   i_value,
  input  logic [NUM_DIGITS-1:0]     i_dp,
  input  logic                      i_lzSuppress,
  input  logic                      i_load,
  output logic                      o_loadAck,
  output logic                      o_frame,
  output logic [7:0]                o_segVals,
  output logic [NUM_DIGITS-1:0]     o_digitSel
);

  localparam int TW         = clog2_min1(TICKS_PER_DIGIT);
  localparam int DW         = clog2_min1(NUM_DIGITS);
  localparam int SHOW_TICKS = TICKS_PER_DIGIT - BLANK_TICKS;

  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_TICKS - 1);
  localparam logic [TW-1:0] SHOW_LAST  = TW'(SHOW_TICKS - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(NUM_DIGITS - 1);

  // XOR masks that convert internal active-high patterns to pin polarity.
  localparam logic [7:0]            SEG_POL = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_POL = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}}
                                                             : {NUM_DIGITS{1'b0}};

  scan_state_t               r_state;
  logic [TW-1:0]             r_tick;
  logic [DW-1:0]             r_digit;
  logic                      r_frame;
  logic [4*NUM_DIGITS-1:0]   r_pendVal;
  logic [NUM_DIGITS-1:0]     r_pendDp;
  logic                      r_pendFlag;
  logic [4*NUM_DIGITS-1:0]   r_dispVal;
  logic [NUM_DIGITS-1:0]     r_dispDp;
  logic [7:0]                r_seg;
  logic [NUM_DIGITS-1:0]     r_sel;

  scan_state_t               w_state_nxt;
  logic [TW-1:0]             w_tick_nxt;
  logic [DW-1:0]             w_digit_nxt;
  logic                      w_frame_nxt;
  logic                      w_xfer;
  logic [4*NUM_DIGITS-1:0]   w_dispVal_nxt;
  logic [NUM_DIGITS-1:0]     w_dispDp_nxt;
  logic [3:0]                w_nibble;
  logic                      w_dp;
  logic                      w_lzBlank;
  logic [6:0]                w_hexSeg;
  logic [7:0]                w_segRaw;
  logic [NUM_DIGITS-1:0]     w_selRaw;

  // Scan FSM: BLANK -> SHOW -> BLANK of the next digit, tick restarts on each entry.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_BLANK;
      r_tick  <= '0;
      r_digit <= '0;
      r_frame <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_tick_nxt;
      r_digit <= w_digit_nxt;
      r_frame <= w_frame_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick + 1'b1;
    w_digit_nxt = r_digit;
    w_frame_nxt = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (r_tick == BLANK_LAST) begin
          w_state_nxt = ST_SHOW;
          w_tick_nxt  = '0;
        end
      end
      ST_SHOW: begin
        if (r_tick == SHOW_LAST) begin
          w_state_nxt = ST_BLANK;
          w_tick_nxt  = '0;
          if (r_digit == DIGIT_LAST) begin
            w_digit_nxt = '0;
            // Entering digit-0 BLANK from a scan is the frame boundary;
            // the post-reset start is not, since it never passes through here.
            w_frame_nxt = 1'b1;
          end else begin
            w_digit_nxt = r_digit + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_tick_nxt  = '0;
      end
    endcase
  end

  // The boundary cycle acknowledges and, at its closing edge, copies the
  // pending data. A load sampled on that same edge lands in pending and
  // keeps the flag set, so it is acknowledged one frame later.
  assign w_xfer    = r_frame & r_pendFlag;
  assign o_loadAck = w_xfer;
  assign o_frame   = r_frame;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pendVal  <= '0;
      r_pendDp   <= '0;
      r_pendFlag <= 1'b0;
      r_dispVal  <= '0;
      r_dispDp   <= '0;
    end else begin
      if (i_load) begin
        r_pendVal  <= i_value;
        r_pendDp   <= i_dp;
        r_pendFlag <= 1'b1;
      end else if (w_xfer) begin
        r_pendFlag <= 1'b0;
      end
      if (w_xfer) begin
        r_dispVal <= r_pendVal;
        r_dispDp  <= r_pendDp;
      end
    end
  end

  // Outputs are registered from next-cycle values so pins match r_state
  // in the same cycle; the display register value used must be next-cycle too.
  assign w_dispVal_nxt = w_xfer ? r_pendVal : r_dispVal;
  assign w_dispDp_nxt  = w_xfer ? r_pendDp  : r_dispDp;

  // Digit mux plus leading-zero detect: walking down from the top digit,
  // v_zeroAbove stays set while every nibble so far (inclusive) is zero.
  always_comb begin
    logic v_zeroAbove;
    v_zeroAbove = 1'b1;
    w_nibble    = 4'h0;
    w_dp        = 1'b0;
    w_lzBlank   = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      v_zeroAbove = v_zeroAbove & (w_dispVal_nxt[4*k +: 4] == 4'h0);
      if (w_digit_nxt == DW'(k)) begin
        w_nibble  = w_dispVal_nxt[4*k +: 4];
        w_dp      = w_dispDp_nxt[k];
        w_lzBlank = i_lzSuppress & v_zeroAbove & (k != 0);
      end
    end
  end

  hex_to_7seg u_hex_to_7seg (
    .i_nibble (w_nibble),
    .o_seg    (w_hexSeg)
  );

  // Suppressed digits keep their select and decimal point; only the glyph goes dark.
  always_comb begin
    w_segRaw = SEG_BLANK;
    w_selRaw = '0;
    if (w_state_nxt == ST_SHOW) begin
      w_segRaw[SEG_G:SEG_A] = w_lzBlank ? 7'h00 : w_hexSeg;
      w_segRaw[SEG_DP]      = w_dp;
      w_selRaw              = NUM_DIGITS'(1) << w_digit_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_seg <= SEG_BLANK ^ SEG_POL;
      r_sel <= DIG_POL;
    end else begin
      r_seg <= w_segRaw ^ SEG_POL;
      r_sel <= w_selRaw ^ DIG_POL;
    end
  end

  assign o_segVals  = r_seg;
  assign o_digitSel = r_sel;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [15:0] i_value;
  logic [3:0]  i_dp;
  logic        i_lzSuppress;
  logic        i_load;
  logic        o_loadAck;
  logic        o_frame;
  logic [7:0]  o_segVals;
  logic [3:0]  o_digitSel;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS      (4),
    .TICKS_PER_DIGIT (8),
    .BLANK_TICKS     (2),
    .DIG_ACTIVE_LOW  (1'b1),
    .SEG_ACTIVE_LOW  (1'b0)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_value      (i_value),
    .i_dp         (i_dp),
    .i_lzSuppress (i_lzSuppress),
    .i_load       (i_load),
    .o_loadAck    (o_loadAck),
    .o_frame      (o_frame),
    .o_segVals    (o_segVals),
    .o_digitSel   (o_digitSel)
  );

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] seg;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endfunction

  // Expected digit windows of one frame, digit 0 first (scan order).
  task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3);
    q.push_back('{sel: 4'b1110, seg: s0});
    q.push_back('{sel: 4'b1101, seg: s1});
    q.push_back('{sel: 4'b1011, seg: s2});
    q.push_back('{sel: 4'b0111, seg: s3});
  endtask

  // Monitor: every start of a digit window pops one expectation; also
  // checks window lengths, blank gap, frame period and counts acks.
  int         cyc = 0;
  int         show_len = 0;
  int         blank_len = 0;
  int         last_frame_cyc = 0;
  bit         have_frame = 1'b0;
  int         ack_cnt = 0;
  logic [3:0] prev_sel = 4'hF;

  always @(negedge clk) begin
    cyc++;
    if (i_reset) begin
      show_len   = 0;
      blank_len  = 0;
      have_frame = 1'b0;
      prev_sel   = 4'hF;
    end else begin
      if (o_digitSel != 4'hF) begin
        if (prev_sel == 4'hF) begin
          if (blank_len > 0) check("blank_gap", blank_len, 2);
          blank_len = 0;
          if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("show_sel", {28'd0, o_digitSel}, {28'd0, e.sel});
            check("show_seg", {24'd0, o_segVals}, {24'd0, e.seg});
          end
        end
        show_len++;
      end else begin
        if (show_len > 0) check("show_len", show_len, 6);
        show_len = 0;
        blank_len++;
      end
      if (o_frame) begin
        if (have_frame) check("frame_period", cyc - last_frame_cyc, 32);
        have_frame     = 1'b1;
        last_frame_cyc = cyc;
      end
      if (o_loadAck) ack_cnt++;
      prev_sel = o_digitSel;
    end
  end

  // Sampled on the next rising edge; call between edges.
  task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
    i_value = v;
    i_dp    = dp;
    i_load  = 1'b1;
    @(posedge clk);
    #1 i_load = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns at the falling edge inside the boundary cycle.
  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_frame && n < 64);
    check("frame_seen", {31'd0, o_frame}, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_reset      = 1'b1;
    i_value      = '0;
    i_dp         = '0;
    i_lzSuppress = 1'b0;
    i_load       = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;

    // A load that a mid-scan reset must discard.
    idle(1);
    do_load(16'hFFFF, 4'hF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_digitSel != 4'b1011 && n < 100);
    check("reach_digit2", {28'd0, o_digitSel}, 32'hB);

    @(posedge clk);
    #1 i_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (i == 2) i_reset = 1'b0;
      @(negedge clk);
      check("reset_sel",   {28'd0, o_digitSel}, 32'hF);
      check("reset_seg",   {24'd0, o_segVals},  32'h0);
      check("reset_ack",   {31'd0, o_loadAck},  0);
      check("reset_frame", {31'd0, o_frame},    0);
    end

    wait_frame();
    check("ack_discard", {31'd0, o_loadAck}, 0);
    push_frame(8'h3f, 8'h3f, 8'h3f, 8'h3f);

    idle(3);
    do_load(16'h1234, 4'h0);
    wait_frame();
    check("ack_1234", {31'd0, o_loadAck}, 1);
    push_frame(8'h66, 8'h4f, 8'h5b, 8'h06);

    idle(3);
    i_lzSuppress = 1'b1;
    do_load(16'h0050, 4'h0);
    wait_frame();
    check("ack_0050", {31'd0, o_loadAck}, 1);
    push_frame(8'h3f, 8'h6d, 8'h00, 8'h00);

    idle(3);
    do_load(16'h0000, 4'h0);
    wait_frame();
    check("ack_0000", {31'd0, o_loadAck}, 1);
    push_frame(8'h3f, 8'h00, 8'h00, 8'h00);

    idle(3);
    do_load(16'hAAAA, 4'h0);
    idle(2);
    do_load(16'hBBBB, 4'h0);
    wait_frame();
    check("ack_B", {31'd0, o_loadAck}, 1);
    push_frame(8'h7c, 8'h7c, 8'h7c, 8'h7c);
    // Load on the boundary cycle itself.
    do_load(16'hCCCC, 4'h0);
    wait_frame();
    check("ack_C", {31'd0, o_loadAck}, 1);
    push_frame(8'h39, 8'h39, 8'h39, 8'h39);

    idle(3);
    do_load(16'h0008, 4'b0001);
    wait_frame();
    check("ack_0008", {31'd0, o_loadAck}, 1);
    push_frame(8'hff, 8'h00, 8'h00, 8'h00);

    wait_frame();
    check("ack_idle", {31'd0, o_loadAck}, 0);
    check("queue_drained", q.size(), 0);
    check("ack_total", ack_cnt, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
